// File: rtl/linebuf_fetch_ctrl_pkg.sv
// Shared types for linebuf_fetch_ctrl: sequencer states and line geometry helper.
package linebuf_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    FILL   = 2'd2
  } state_t;

  function automatic int unsigned line_words(input int unsigned lgline);
    return 32'd1 << lgline;
  endfunction

endpackage

// File: rtl/linebuf_fetch_ctrl_iscachable.sv
// iscachable: combinational region decode; an address is cachable if it falls in
// any of the SDRAM, block RAM or flash windows.
module iscachable #(
  parameter int            AW         = 28,
  parameter logic [AW-1:0] SDRAM_ADDR = 28'h200_0000,
  parameter logic [AW-1:0] SDRAM_MASK = 28'h200_0000,
  parameter logic [AW-1:0] BKRAM_ADDR = 28'h400_0000,
  parameter logic [AW-1:0] BKRAM_MASK = 28'h440_0000,
  parameter logic [AW-1:0] FLASH_ADDR = 28'h200_0000,
  parameter logic [AW-1:0] FLASH_MASK = 28'h200_0000
) (
  input  logic [AW-1:0] i_addr,
  output logic          o_cachable
);

  always_comb begin
    o_cachable = ((i_addr & SDRAM_MASK) == SDRAM_ADDR)
              || ((i_addr & BKRAM_MASK) == BKRAM_ADDR)
              || ((i_addr & FLASH_MASK) == FLASH_ADDR);
  end

endmodule

// File: rtl/linebuf_fetch_ctrl.sv
// linebuf_fetch_ctrl: single-line read buffer and Wishbone pipelined sequencer.
// Define EARLY_RETURN_EN to return the requested word on its own fill ack.
module linebuf_fetch_ctrl
  import linebuf_fetch_ctrl_pkg::*;
#(
  parameter int            AW         = 28,
  parameter int            DW         = 32,
  parameter int            LGLINE     = 3,
  parameter logic [AW-1:0] SDRAM_ADDR = 28'h200_0000,
  parameter logic [AW-1:0] SDRAM_MASK = 28'h200_0000,
  parameter logic [AW-1:0] BKRAM_ADDR = 28'h400_0000,
  parameter logic [AW-1:0] BKRAM_MASK = 28'h440_0000,
  parameter logic [AW-1:0] FLASH_ADDR = 28'h200_0000,
  parameter logic [AW-1:0] FLASH_MASK = 28'h200_0000
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_clear,
  input  logic            i_stb,
  input  logic            i_we,
  input  logic [AW-1:0]   i_addr,
  input  logic [DW-1:0]   i_data,
  input  logic [DW/8-1:0] i_sel,
  output logic            o_busy,
  output logic            o_valid,
  output logic            o_err,
  output logic [DW-1:0]   o_data,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data
);

  localparam int unsigned     LINE = line_words(LGLINE);
  localparam int              TW   = AW - LGLINE;
  localparam logic [LGLINE:0] LAST = (LGLINE+1)'(LINE - 1);

  state_t            state, state_next;
  logic              line_valid, discard, stb, cachable, hit, fill_done;
  logic [TW-1:0]     line_tag, req_tag;
  logic [LGLINE-1:0] req_idx;
  logic [LGLINE:0]   stb_count, ack_count;
  logic [DW-1:0]     line_buf [LINE];

  iscachable #(
    .AW(AW),
    .SDRAM_ADDR(SDRAM_ADDR), .SDRAM_MASK(SDRAM_MASK),
    .BKRAM_ADDR(BKRAM_ADDR), .BKRAM_MASK(BKRAM_MASK),
    .FLASH_ADDR(FLASH_ADDR), .FLASH_MASK(FLASH_MASK)
  ) u_iscachable (
    .i_addr    (i_addr),
    .o_cachable(cachable)
  );

  always_comb begin
    req_tag   = i_addr[AW-1:LGLINE];
    hit       = line_valid && (req_tag == line_tag) && cachable && !i_we;
    fill_done = (state == FILL) && i_wb_ack && !i_wb_err && (ack_count == LAST);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_stb && !hit) state_next = (cachable && !i_we) ? FILL : SINGLE;
      SINGLE:  if (i_wb_err || i_wb_ack) state_next = IDLE;
      FILL:    if (i_wb_err || fill_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // cyc follows the state register so an async reset drops it at once
  always_comb begin
    o_busy   = (state != IDLE);
    o_wb_cyc = (state != IDLE);
    o_wb_stb = stb;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_valid    <= 1'b0;
      o_err      <= 1'b0;
      o_data     <= '0;
      o_wb_we    <= 1'b0;
      o_wb_addr  <= '0;
      o_wb_data  <= '0;
      o_wb_sel   <= '0;
      stb        <= 1'b0;
      line_valid <= 1'b0;
      discard    <= 1'b0;
      line_tag   <= '0;
      req_idx    <= '0;
      stb_count  <= '0;
      ack_count  <= '0;
    end else begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (i_clear) line_valid <= 1'b0;
          if (i_stb) begin
            if (hit) begin
              o_valid <= 1'b1;
              o_data  <= line_buf[i_addr[LGLINE-1:0]];
            end else if (cachable && !i_we) begin
              line_valid <= 1'b0;
              discard    <= i_clear;
              line_tag   <= req_tag;
              req_idx    <= i_addr[LGLINE-1:0];
              o_wb_addr  <= {req_tag, {LGLINE{1'b0}}};
              o_wb_we    <= 1'b0;
              o_wb_sel   <= '1;
              stb        <= 1'b1;
              stb_count  <= '0;
              ack_count  <= '0;
            end else begin
              o_wb_addr <= i_addr;
              o_wb_we   <= i_we;
              o_wb_data <= i_data;
              o_wb_sel  <= i_sel;
              stb       <= 1'b1;
              if (i_we && (req_tag == line_tag)) line_valid <= 1'b0;
            end
          end
        end
        SINGLE: begin
          if (i_clear) line_valid <= 1'b0;
          if (!i_wb_stall) stb <= 1'b0;
          if (i_wb_err) begin
            stb        <= 1'b0;
            o_err      <= 1'b1;
            line_valid <= 1'b0;
          end else if (i_wb_ack) begin
            stb     <= 1'b0;
            o_valid <= 1'b1;
            if (!o_wb_we) o_data <= i_wb_data;
          end
        end
        FILL: begin
          if (i_clear) discard <= 1'b1;
          if (stb && !i_wb_stall) begin
            o_wb_addr <= o_wb_addr + 1'b1;
            stb_count <= stb_count + 1'b1;
            if (stb_count == LAST) stb <= 1'b0;
          end
          if (i_wb_err) begin
            stb        <= 1'b0;
            o_err      <= 1'b1;
            line_valid <= 1'b0;
          end else if (i_wb_ack) begin
            ack_count <= ack_count + 1'b1;
`ifdef EARLY_RETURN_EN
            if (ack_count[LGLINE-1:0] == req_idx) begin
              o_valid <= 1'b1;
              o_data  <= i_wb_data;
            end
            if (fill_done) line_valid <= !discard && !i_clear;
`else
            // requested word may be the one arriving on this final ack
            if (fill_done) begin
              line_valid <= !discard && !i_clear;
              o_valid    <= 1'b1;
              o_data     <= (ack_count[LGLINE-1:0] == req_idx) ? i_wb_data
                                                               : line_buf[req_idx];
            end
`endif
          end
        end
        default: stb <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if ((state == FILL) && i_wb_ack && !i_wb_err)
      line_buf[ack_count[LGLINE-1:0]] <= i_wb_data;
  end

`ifdef FORMAL
  always_ff @(posedge i_clk) begin
    if (i_reset_n && o_busy) assert (!i_stb);
  end
`endif

endmodule

// File: doc/linebuf_fetch_ctrl.md
Name: linebuf_fetch_ctrl

Overview:
- Single-line read buffer and Wishbone sequencer between a CPU load/store port and the pipelined bus.
- Classifies each request with the codebase's iscachable helper:
  - cachable reads are served from one 2^LGLINE-word line buffer, filled by a burst on a miss;
  - uncachable reads and all writes go out as single bus transactions.
- Sits between the ZipCPU memory pipe and the bus interconnect; a lightweight alternative to the full dcache.

Parameters:
- AW, 28, word address width.
- DW, 32, data width.
- LGLINE, 3, log2 words per line (line = 8 words).
- SDRAM_ADDR/SDRAM_MASK, 28'h200_0000/28'h200_0000, cachable region passed to iscachable.
- BKRAM_ADDR/BKRAM_MASK, 28'h400_0000/28'h440_0000, cachable region passed to iscachable.
- FLASH_ADDR/FLASH_MASK, 28'h200_0000/28'h200_0000, cachable region passed to iscachable.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_clear  in  1  invalidate line buffer
- i_stb  in  1  request strobe, legal only when o_busy=0
- i_we  in  1  1=write
- i_addr  in  AW  word address
- i_data  in  DW  write data
- i_sel  in  DW/8  byte selects
- o_busy  out  1  request in progress
- o_valid  out  1  one-cycle pulse, read data/write ack
- o_err  out  1  one-cycle bus error pulse
- o_data  out  DW  read data
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone pipelined master
- o_wb_addr  out  AW  bus address
- o_wb_data  out  DW  bus write data
- o_wb_sel  out  DW/8  bus byte selects
- i_wb_stall, i_wb_ack, i_wb_err  in  1 each  Wishbone pipelined responses
- i_wb_data  in  DW  bus read data

Behaviour:
- Reset (async, i_reset_n=0):
  - state IDLE; line invalid.
  - o_busy, o_valid, o_err, o_wb_cyc, o_wb_stb, o_wb_we = 0.
  - o_data, o_wb_addr = 0.
  - cyc drops immediately, even mid-burst.
- Tag = i_addr[AW-1:LGLINE]; hit = line_valid && tag==line_tag && cachable && !i_we.
- IDLE, i_stb on a hit: o_valid with buffer word next cycle (latency 1); o_busy stays 0.
- IDLE, i_stb on a cachable read miss → FILL:
  - line_valid cleared; tag latched.
  - o_wb_addr = {tag, LGLINE'b0}, cyc=stb=1, we=0, sel all ones.
- FILL:
  - address increments per accepted strobe (stb && !stall).
  - stb drops after 2^LGLINE accepts; each ack writes i_wb_data into buffer[ackcount].
  - After the final ack: cyc=0, o_valid with the requested word, line_valid=1 unless a clear was seen during the fill, → IDLE.
  - Fill latency ≥ 2^LGLINE+2 cycles.
- IDLE, i_stb on an uncachable read or any write → SINGLE:
  - one strobe with the request's we/addr/data/sel.
  - ack → o_valid, o_data=i_wb_data (reads), cyc=0, → IDLE.
  - A write whose tag equals line_tag clears line_valid when issued.
- o_busy = 1 throughout FILL/SINGLE; the stall/ack counters are LGLINE+1 bits wide.
- i_wb_err in any state: cyc=stb=0 same edge, o_err pulse, line_valid=0, → IDLE; acks after the error are ignored.
- i_clear:
  - in IDLE, line_valid=0 next cycle.
  - in FILL, sets a discard flag: the fill completes and the requested word is returned, but the line is left invalid.
  - clear coincident with an IDLE hit: the hit is served, then invalidated.
- i_stb while o_busy=1 is a protocol violation: ignored, flagged by a formal assertion.
- Line at top of the address space: base computation only, no wrap issue.

Optional Feature:
- EARLY_RETURN_EN defined:
  - during FILL, o_valid/o_data fire on the ack carrying the requested word;
  - o_busy remains 1 until the line completes;
  - no second o_valid at fill end.
- Undefined: o_valid only after the final fill ack.

Decomposition:
- Shared package: state encoding (IDLE, SINGLE, FILL); line word count constant derived from LGLINE.
- Sub-module: the existing iscachable, instantiated combinationally on i_addr with the region parameters passed through.
- Line buffer is an inline register array.

Test Plan:
- Read 0x200_0013 cold, no stall:
  - 8 strobes at 0x200_0010..0x200_0017 with data 0xA0..0xA7;
  - o_valid with o_data=0xA3 one cycle after the last ack;
  - immediate read 0x200_0015 → o_valid next cycle, 0xA5, zero bus activity.
- Uncachable read 0x010_0004 → exactly one strobe; ack data 0xDEADBEEF → o_valid, o_data=0xDEADBEEF; line state unchanged.
- Write 0x200_0012 after the fill above → single write strobe; a subsequent read of 0x200_0012 causes a full refill.
- i_wb_err on the 4th ack of a fill → cyc low the same edge, one o_err pulse, o_busy=0, next read of the line re-fills.
- i_clear asserted mid-fill → requested word still returned, next read of the same line misses.
- Random stalls (50%) during fill, plus reset_n pulsed low mid-burst → cyc drops asynchronously, all outputs 0; post-reset read refills correctly.
- Repeat the cold-read case with EARLY_RETURN_EN → o_valid aligned with the 4th ack.
